// File: rtl/aes_pkg.sv
// Shared widths and feeder state encoding for the AES-256 CTR issue path.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;
  localparam int CTR_W     = 32;
  localparam int NONCE_W   = 96;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feed_st_e;
endpackage

// File: rtl/aes_ctr_feeder_if.sv
// Job configuration channel into the CTR feeder (valid/ready).
interface aes_ctr_feeder_if;
  import aes_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [AES_KEY_W-1:0] cfg_key;
  logic [NONCE_W-1:0]   cfg_nonce;
  logic [CTR_W-1:0]     cfg_ctr0;
  logic [CTR_W-1:0]     cfg_nblocks;

  modport master (
    output cfg_valid,
    output cfg_key,
    output cfg_nonce,
    output cfg_ctr0,
    output cfg_nblocks,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_key,
    input  cfg_nonce,
    input  cfg_ctr0,
    input  cfg_nblocks,
    output cfg_ready
  );
endinterface

// File: rtl/aes_tag_delay.sv
// Resettable shift register for the narrow valid+index tag; the MSB of
// each word is the valid bit, and busy reports any valid still in flight.
module aes_tag_delay #(
  parameter int DEPTH = 65,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         busy
);
  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | sr_q[i][W-1];
    end
  end

  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/aes_ctr_feeder.sv
// AES-256 CTR feeder: streams {nonce,ctr} blocks into a fixed-latency
// core, credit-gated against the output FIFO, with a valid/index tag line.
module aes_ctr_feeder
  import aes_pkg::*;
#(
  parameter int CORE_LAT = 64,
  parameter int CREDITS  = 16,
  parameter int IDX_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_ctr_feeder_if.slave      cfg,
  input  logic                 abort,
  input  logic                 credit_ret,
  output logic [AES_BLK_W-1:0] core_state,
  output logic [AES_KEY_W-1:0] core_key,
  output logic                 core_in_vld,
  output logic                 out_vld,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 busy,
  output logic                 done
);
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  feed_st_e             st_q, st_d;
  logic [CRD_W-1:0]     crd_q, crd_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [CTR_W-1:0]     rem_q, rem_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic                 vld_q, vld_d;
  logic                 done_q, done_d;
  logic                 issue;
  logic                 tag_busy;
  logic [IDX_W:0]       tag_out;

  always_comb begin
    issue   = (st_q == RUN) && (rem_q != '0) &&
              (crd_q != '0) && !abort;
    st_d    = st_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    nonce_d = nonce_q;
    key_d   = key_q;
    blk_d   = blk_q;
    vld_d   = issue;
    done_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (cfg.cfg_valid) begin
          key_d   = cfg.cfg_key;
          nonce_d = cfg.cfg_nonce;
          ctr_d   = cfg.cfg_ctr0;
          rem_d   = cfg.cfg_nblocks;
          idx_d   = '0;
          if (cfg.cfg_nblocks == '0) done_d = 1'b1;
          else                       st_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          st_d = DRAIN;
        end else if (issue) begin
          blk_d = {nonce_q, ctr_q};
          ctr_d = ctr_q + CTR_W'(1);
          rem_d = rem_q - CTR_W'(1);
          idx_d = idx_q + IDX_W'(1);
          if (rem_q == CTR_W'(1)) st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!tag_busy && !vld_q) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // A return at full credit is a consumer bug; hold the count there.
  always_comb begin
    crd_d = crd_q;
    if (issue && !credit_ret) begin
      crd_d = crd_q - CRD_W'(1);
    end else if (credit_ret && !issue && crd_q != CRD_MAX) begin
      crd_d = crd_q + CRD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      crd_q   <= CRD_MAX;
      ctr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      nonce_q <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      crd_q   <= crd_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      nonce_q <= nonce_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  crd_ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(credit_ret && !issue && crd_q == CRD_MAX));

  // First stage mirrors core_in_vld, so the last stage lands CORE_LAT later.
  aes_tag_delay #(
    .DEPTH (CORE_LAT + 1),
    .W     (IDX_W + 1)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({issue, idx_q}),
    .dout  (tag_out),
    .busy  (tag_busy)
  );

  assign cfg.cfg_ready = (st_q == IDLE);
  assign core_state    = blk_q;
  assign core_key      = key_q;
  assign core_in_vld   = vld_q;
  assign out_vld       = tag_out[IDX_W];
  assign out_idx       = tag_out[IDX_W-1:0];
  assign busy          = (st_q != IDLE);
  assign done          = done_q;
endmodule
